// File: rtl/prime_pkg.sv
// Shared types and constants for the prime range scanner.
package prime_pkg;

    // Candidate width; the external detector is a fixed 4-bit block.
    localparam int unsigned PRIME_W = 4;

    // Default width of the prime counter (at most 6 primes exist below 16).
    localparam int unsigned PRIME_CNT_W = 5;

    // Bit k set when k is prime, for k in 0..15.
    localparam logic [15:0] PRIME_MAP_4B = 16'h28AC;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StEmit,
        StDone
    } scan_state_e;

endpackage

// File: rtl/prime_scan_ctrl_if.sv
// Valid/ready stream carrying each prime found by the scanner.
interface prime_scan_ctrl_if;
    import prime_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [PRIME_W-1:0] out_data;

    // Producer side: the scanner.
    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Consumer side.
    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/prime_out_reg.sv
// Holding register for one stream beat; clear takes priority over load.
module prime_out_reg
    import prime_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [PRIME_W-1:0] data_i,
    input  logic               clear_i,
    output logic               valid_o,
    output logic [PRIME_W-1:0] data_o
);

    logic               valid_q, valid_d;
    logic [PRIME_W-1:0] data_q, data_d;

    // Next-state: data is only replaced on load, so it stays stable while stalled.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/prime_scan_ctrl.sv
// Sweeps [lo, hi] through an external prime detector, streaming each prime found
// and accumulating a count and a bitmap of the primes seen.
module prime_scan_ctrl
    import prime_pkg::*;
#(
    parameter int unsigned W     = PRIME_W,
    parameter int unsigned CNT_W = PRIME_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W-1:0]        lo,
    input  logic [W-1:0]        hi,
    input  logic                abort,
    output logic [W-1:0]        num,
    input  logic                is_prime,
    prime_scan_ctrl_if.master   out_if,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    prime_count,
    output logic [(2**W)-1:0]   prime_map
);

    localparam int unsigned MapW = 2 ** W;

    scan_state_e      st_q, st_d;
    logic [W-1:0]     cur_q, cur_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [MapW-1:0]  map_q, map_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             emit_load;
    logic             emit_clear;
    logic             emit_fire;
    logic             at_hi;

    // Compare before increment so hi=15 ends the scan without wrapping cur.
    assign at_hi     = (cur_q == hi_q);
    assign emit_fire = out_if.out_valid && out_if.out_ready;

    // Sequencer next-state; abort outranks every other action in a scan.
    always_comb begin
        st_d       = st_q;
        cur_d      = cur_q;
        hi_d       = hi_q;
        count_d    = count_q;
        map_d      = map_q;
        err_d      = err_q;
        done_d     = 1'b0;
        emit_load  = 1'b0;
        emit_clear = 1'b0;

        unique case (st_q)
            StIdle: begin
                if (start && !abort) begin
                    cur_d   = lo;
                    hi_d    = hi;
                    count_d = '0;
                    map_d   = '0;
                    err_d   = (lo > hi);
                    st_d    = (lo > hi) ? StDone : StEval;
                end
            end
            StEval: begin
                if (abort) begin
                    st_d = StIdle;
                end else if (is_prime) begin
                    emit_load    = 1'b1;
                    count_d      = count_q + CNT_W'(1);
                    map_d[cur_q] = 1'b1;
                    st_d         = StEmit;
                end else if (at_hi) begin
                    st_d = StDone;
                end else begin
                    cur_d = cur_q + W'(1);
                end
            end
            StEmit: begin
                if (abort) begin
                    emit_clear = 1'b1;
                    st_d       = StIdle;
                end else if (emit_fire) begin
                    emit_clear = 1'b1;
                    if (at_hi) begin
                        st_d = StDone;
                    end else begin
                        cur_d = cur_q + W'(1);
                        st_d  = StEval;
                    end
                end
            end
            StDone: begin
                // done is registered, so it pulses on the cycle after this one.
                done_d = !abort;
                st_d   = StIdle;
            end
            default: begin
                st_d = StIdle;
            end
        endcase
    end

    // Sequencer state and registered results, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            cur_q   <= '0;
            hi_q    <= '0;
            count_q <= '0;
            map_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cur_q   <= cur_d;
            hi_q    <= hi_d;
            count_q <= count_d;
            map_q   <= map_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    prime_out_reg u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (emit_load),
        .data_i  (cur_q),
        .clear_i (emit_clear),
        .valid_o (out_if.out_valid),
        .data_o  (out_if.out_data)
    );

    assign num         = cur_q;
    assign busy        = (st_q == StEval) || (st_q == StEmit);
    assign done        = done_q;
    assign err         = err_q;
    assign prime_count = count_q;
    assign prime_map   = map_q;

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Randomized self-checking bench for prime_scan_ctrl against a range/primality model.
module tb_prime_scan_ctrl;
    import prime_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic        abort;
    logic [3:0]  num;
    logic        is_prime;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  prime_count;
    logic [15:0] prime_map;

    int n_vec = 0;
    int n_bad = 0;

    prime_scan_ctrl_if sif ();

    prime_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .lo          (lo),
        .hi          (hi),
        .abort       (abort),
        .num         (num),
        .is_prime    (is_prime),
        .out_if      (sif),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .prime_count (prime_count),
        .prime_map   (prime_map)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Trial-division primality, standing in for the external detector.
    function automatic logic ref_is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) begin
            if (v % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    assign is_prime = ref_is_prime(int'(num));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One scan with a consumer that stalls randomly and optionally on one value.
    task automatic do_scan(input logic [3:0] l, input logic [3:0] h, input int rdy_pct,
                           input int stall_val, input int stall_len, input bit poke_start);
        logic [3:0]  exp_q[$];
        logic [3:0]  got_q[$];
        logic [15:0] exp_map;
        logic [3:0]  held;
        bit          exp_err;
        bit          was_stalled;
        int          span;
        int          n;
        int          done_at;
        int          busy_cnt;
        int          stalls;
        int          stall_left;

        exp_map = '0;
        held    = '0;
        exp_err = (l > h);
        span    = 0;
        if (!exp_err) begin
            span = int'(h) - int'(l) + 1;
            for (int v = int'(l); v <= int'(h); v++) begin
                if (ref_is_prime(v)) begin
                    exp_q.push_back(4'(v));
                    exp_map[v] = 1'b1;
                end
            end
        end

        start = 1'b1;
        lo    = l;
        hi    = h;
        @(posedge clk);
        #1;
        start       = 1'b0;
        n           = 0;
        done_at     = -1;
        busy_cnt    = 0;
        stalls      = 0;
        stall_left  = stall_len;
        was_stalled = 1'b0;

        while (n < 400) begin
            if (done) begin
                done_at = n;
                break;
            end
            if (busy) busy_cnt++;
            if (poke_start && n == 3) begin
                start = 1'b1;
                lo    = 4'd1;
                hi    = 4'd2;
            end else begin
                start = 1'b0;
            end
            if (was_stalled) begin
                check_eq("valid_held", sif.out_valid, 1);
                check_eq("data_held", sif.out_data, held);
            end
            if (sif.out_valid) begin
                check_eq("num_eq_data", num, sif.out_data);
                if (stall_left > 0 && int'(sif.out_data) == stall_val) begin
                    sif.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    sif.out_ready = ($urandom_range(99) < rdy_pct);
                end
                if (sif.out_ready) begin
                    got_q.push_back(sif.out_data);
                    was_stalled = 1'b0;
                end else begin
                    stalls++;
                    was_stalled = 1'b1;
                    held        = sif.out_data;
                end
            end else begin
                was_stalled   = 1'b0;
                sif.out_ready = 1'($urandom_range(1));
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;

        if (done_at < 0) begin
            check_eq("done_timeout", 0, 1);
        end else begin
            check_eq("done_latency", done_at, span + exp_q.size() + stalls + 1);
            check_eq("busy_cycles", busy_cnt, span + exp_q.size() + stalls);
        end
        check_eq("count", prime_count, exp_q.size());
        check_eq("map", prime_map, exp_map);
        check_eq("err", err, exp_err);
        check_eq("stream_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq("stream_val", got_q[i], exp_q[i]);
        end
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_valid", sif.out_valid, 0);
        sif.out_ready = 1'b1;
    endtask

    initial begin
        int n;
        logic [3:0] rl;
        logic [3:0] rh;

        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        lo            = '0;
        hi            = '0;
        sif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_eq("rst_num", num, 0);
        check_eq("rst_valid", sif.out_valid, 0);
        check_eq("rst_data", sif.out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_count", prime_count, 0);
        check_eq("rst_map", prime_map, 0);

        // Full sweep, then empty range, single value and range error.
        do_scan(4'd0, 4'd15, 100, -1, 0, 1'b0);
        check_eq("sweep_map_const", prime_map, PRIME_MAP_4B);
        do_scan(4'd8, 4'd10, 100, -1, 0, 1'b0);
        do_scan(4'd13, 4'd13, 100, -1, 0, 1'b0);
        do_scan(4'd12, 4'd3, 100, -1, 0, 1'b0);

        // abort together with start in IDLE: start is not accepted, err holds.
        start = 1'b1;
        abort = 1'b1;
        lo    = 4'd0;
        hi    = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check_eq("abort_start_busy", busy, 0);
        check_eq("abort_start_err", err, 1);

        // Backpressure: five stall cycles on the prime 3.
        do_scan(4'd0, 4'd15, 100, 3, 5, 1'b0);

        // Abort during the EMIT of 5.
        start = 1'b1;
        lo    = 4'd0;
        hi    = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        while (n < 100 && !(sif.out_valid && sif.out_data == 4'd5)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("abort_reach5", sif.out_valid, 1);
        sif.out_ready = 1'b0;
        abort         = 1'b1;
        @(posedge clk);
        #1;
        abort         = 1'b0;
        sif.out_ready = 1'b1;
        check_eq("abort_valid", sif.out_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_count", prime_count, 3);
        check_eq("abort_map", prime_map, 16'h002C);
        for (int i = 0; i < 3; i++) begin
            check_eq("abort_no_done", done, 0);
            @(posedge clk);
            #1;
        end
        do_scan(4'd0, 4'd3, 100, -1, 0, 1'b0);

        // Reset during the EVAL of 4, after 2 and 3 were emitted.
        start = 1'b1;
        lo    = 4'd0;
        hi    = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        while (n < 100 && !(busy && num == 4'd4 && !sif.out_valid)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("rst_reach4", num, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("mid_rst_num", num, 0);
        check_eq("mid_rst_valid", sif.out_valid, 0);
        check_eq("mid_rst_data", sif.out_data, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_err", err, 0);
        check_eq("mid_rst_count", prime_count, 0);
        check_eq("mid_rst_map", prime_map, 0);
        for (int i = 0; i < 3; i++) begin
            check_eq("mid_rst_no_done", done, 0);
            @(posedge clk);
            #1;
        end

        // Start pulsed while busy must be ignored.
        do_scan(4'd0, 4'd15, 100, -1, 0, 1'b1);

        // Random ranges (including lo>hi) with random backpressure.
        for (int k = 0; k < 30; k++) begin
            rl = 4'($urandom_range(15));
            rh = 4'($urandom_range(15));
            do_scan(rl, rh, int'($urandom_range(30, 100)), -1, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/prime_scan_ctrl.md
Name: prime_scan_ctrl

Overview:
Sequencer that sweeps an inclusive 4-bit range [lo, hi] through the existing combinational prime detector, one candidate per evaluation cycle. Each prime found is emitted on a valid/ready stream. A prime count and a 16-bit prime bitmap are accumulated and held after completion. The block sits between a host (start/range/abort) and the prime detector (num out, is_prime in).

Parameters:
- W, 4, candidate width; fixed to match the detector; other values unsupported.
- CNT_W, 5, width of prime_count.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a scan; sampled only in IDLE.
- lo  input  4  range low bound; latched on start accept.
- hi  input  4  range high bound; latched on start accept.
- abort  input  1  cancel the scan; returns to IDLE.
- num  output  4  candidate driven to the detector.
- is_prime  input  1  detector result for num, same cycle (combinational).
- out_valid  output  1  prime available on out_data.
- out_ready  input  1  consumer accepts out_data when out_valid=1.
- out_data  output  4  prime value.
- busy  output  1  high in EVAL/EMIT.
- done  output  1  one-cycle pulse on scan completion.
- err  output  1  range error (lo>hi); held until next accepted start.
- prime_count  output  CNT_W  number of primes found in the last/current scan.
- prime_map  output  16  bit k set if k was found prime.

Behaviour:
- Reset: state=IDLE; num, out_data, prime_count, prime_map = 0; out_valid, busy, done, err = 0. Reset mid-scan discards the scan and emits no done.
- States: IDLE, EVAL, EMIT, DONE. busy = (state==EVAL or EMIT).
- IDLE: on start=1, latch lo/hi, set cur<=lo, and clear count, map and err.
  - If lo>hi: set err<=1 and go to DONE.
  - Otherwise go to EVAL.
- num = cur in all states; num holds its last value in IDLE/DONE.
- EVAL (one cycle per candidate):
  - If is_prime: out_data<=cur, out_valid<=1, prime_count+1, prime_map[cur]<=1, go to EMIT.
  - Else if cur==hi: go to DONE.
  - Else: cur<=cur+1 and stay in EVAL.
- EMIT: hold out_valid, out_data and num stable until out_valid&&out_ready. On that cycle:
  - out_valid<=0.
  - If cur==hi, go to DONE; else cur<=cur+1 and go to EVAL.
- The cur==hi compare happens before any increment, so hi=15 never wraps cur to 0 and never re-scans.
- DONE: done=1 for exactly one cycle, then IDLE. count, map and err hold until the next accepted start.
- start in any state other than IDLE is ignored, including the DONE cycle.
- abort=1 in EVAL/EMIT/DONE: go to IDLE next cycle, out_valid<=0, no done pulse. count and map keep their partial values.
- abort and start asserted together in IDLE: abort wins; the start is not accepted.
- rst has priority over abort and start.
- Latency: start accept to first EVAL is 1 cycle. Each non-prime costs 1 cycle. Each prime costs 1 cycle plus the number of EMIT cycles until out_ready.
- Full sweep 0..15 with out_ready=1: 16 EVAL + 6 EMIT = 22 cycles, then the done cycle.
- Count saturation is not needed: at most 6 primes exist below 16.

Decomposition:
- Shared package prime_pkg holds the state enum (IDLE/EVAL/EMIT/DONE), the W=4 constant, and the PRIME_MAP_4B=16'h28AC reference constant for benches.
- The detector stays external, connected through num/is_prime.
- One natural sub-module: prime_out_reg, a valid/ready holding register for out_data/out_valid.

Test Plan:
- Full sweep: lo=0, hi=15, out_ready=1. Stream must be 2,3,5,7,11,13; prime_count=6; prime_map=16'h28AC; done pulses exactly 23 cycles after the start-accept edge; busy high for 22 cycles.
- Empty range: lo=8, hi=10. No out_valid; count=0; map=0; done 4 cycles after accept.
- Single value and error: lo=hi=13 gives one output 13, count=1, map=16'h2000. Then lo=12, hi=3 gives err=1, count=0, and done on the cycle after accept.
- Backpressure: lo=0, hi=15, out_ready held low 5 cycles when out_data=3. out_data and num stay 3, out_valid stays 1, no candidate is skipped, and final count=6.
- Abort/reset mid-scan: abort during the EMIT of 5 gives IDLE next cycle, out_valid=0, no done, count=3. A new start with lo=0, hi=3 then yields count=2. rst during EVAL clears all outputs to 0.
- Ignored start: pulse start with new lo/hi while busy. The scan continues on the original range and final results are unchanged.
